// File: rtl/cmd_link.sv
// Byte-stream front end for fcr: assembles big-endian 32-bit command words from rx bytes
// and serializes 32-bit response words onto a valid/ready byte stream.
module cmd_link #(
    parameter int unsigned TIMEOUT = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_byte,
    input  logic        rx_valid,
    output logic [7:0]  tx_byte,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [31:0] cmd_data,
    output logic        cmd_waitreq,
    input  logic        cmd_rdreq,
    input  logic [31:0] rsp_data,
    input  logic        rsp_wrreq,
    output logic        rsp_waitreq,
    output logic        ovf,
    input  logic        err_clr
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } ser_state_e;

    localparam logic [15:0] TIMEOUT_C  = 16'(TIMEOUT);
    localparam logic        TIMEOUT_EN = (TIMEOUT != 0);

    logic [23:0] asm_q,       asm_d;
    logic [1:0]  cnt_q,       cnt_d;
    logic [15:0] gap_q,       gap_d;
    logic [31:0] pend_word_q, pend_word_d;
    logic        pend_vld_q,  pend_vld_d;
    logic [31:0] cmd_data_q,  cmd_data_d;
    logic        cmd_wait_q,  cmd_wait_d;
    logic        ovf_q,       ovf_d;
    ser_state_e  state_q,     state_d;
    logic [31:0] tx_sr_q,     tx_sr_d;
    logic [1:0]  tx_idx_q,    tx_idx_d;

    logic        timeout_hit_s;
    logic [1:0]  cnt_eff_s;
    logic        word_done_s;
    logic        rd_accept_s;
    logic        ovf_set_s;

    // Next-state logic for assembler, read port, serializer and error flag
    always_comb begin
        asm_d       = asm_q;
        cnt_d       = cnt_q;
        gap_d       = gap_q;
        pend_word_d = pend_word_q;
        pend_vld_d  = pend_vld_q;
        cmd_data_d  = cmd_data_q;
        state_d     = state_q;
        tx_sr_d     = tx_sr_q;
        tx_idx_d    = tx_idx_q;
        ovf_set_s   = 1'b0;

        // A byte arriving on the timeout cycle starts a fresh word
        timeout_hit_s = TIMEOUT_EN && (cnt_q != 2'd0) && (gap_q == TIMEOUT_C);
        cnt_eff_s     = timeout_hit_s ? 2'd0 : cnt_q;
        word_done_s   = rx_valid && (cnt_eff_s == 2'd3);
        rd_accept_s   = cmd_rdreq && pend_vld_q;

        if (rx_valid) begin
            gap_d = 16'd0;
            asm_d = {asm_q[15:0], rx_byte};
            cnt_d = cnt_eff_s + 2'd1;
        end else begin
            gap_d = (gap_q != 16'hFFFF) ? gap_q + 16'd1 : gap_q;
            cnt_d = cnt_eff_s;
        end

        if (rd_accept_s) begin
            cmd_data_d = pend_word_q;
            pend_vld_d = 1'b0;
        end else begin
            cmd_data_d = cmd_data_q;
        end

        if (word_done_s) begin
            if (!pend_vld_q || rd_accept_s) begin
                pend_word_d = {asm_q, rx_byte};
                pend_vld_d  = 1'b1;
            end else begin
                ovf_set_s = 1'b1;
            end
        end else begin
            pend_word_d = pend_word_q;
        end

        cmd_wait_d = !pend_vld_d;

        case (state_q)
            S_IDLE: begin
                if (rsp_wrreq) begin
                    tx_sr_d  = rsp_data;
                    tx_idx_d = 2'd0;
                    state_d  = S_BUSY;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_BUSY: begin
                if (rsp_wrreq) begin
                    ovf_set_s = 1'b1;
                end else begin
                    ovf_set_s = ovf_set_s;
                end
                // Shifting in zeros leaves tx_byte at 0 once the last byte goes out
                if (tx_ready) begin
                    tx_sr_d  = {tx_sr_q[23:0], 8'h00};
                    tx_idx_d = tx_idx_q + 2'd1;
                    state_d  = (tx_idx_q == 2'd3) ? S_IDLE : S_BUSY;
                end else begin
                    state_d = S_BUSY;
                end
            end
            default: begin
                state_d  = S_IDLE;
                tx_sr_d  = 32'h0000_0000;
                tx_idx_d = 2'd0;
            end
        endcase

        if (ovf_set_s) begin
            ovf_d = 1'b1;
        end else if (err_clr) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            asm_q       <= 24'h00_0000;
            cnt_q       <= 2'd0;
            gap_q       <= 16'd0;
            pend_word_q <= 32'h0000_0000;
            pend_vld_q  <= 1'b0;
            cmd_data_q  <= 32'h0000_0000;
            cmd_wait_q  <= 1'b1;
            ovf_q       <= 1'b0;
            state_q     <= S_IDLE;
            tx_sr_q     <= 32'h0000_0000;
            tx_idx_q    <= 2'd0;
        end else begin
            asm_q       <= asm_d;
            cnt_q       <= cnt_d;
            gap_q       <= gap_d;
            pend_word_q <= pend_word_d;
            pend_vld_q  <= pend_vld_d;
            cmd_data_q  <= cmd_data_d;
            cmd_wait_q  <= cmd_wait_d;
            ovf_q       <= ovf_d;
            state_q     <= state_d;
            tx_sr_q     <= tx_sr_d;
            tx_idx_q    <= tx_idx_d;
        end
    end

    assign cmd_data    = cmd_data_q;
    assign cmd_waitreq = cmd_wait_q;
    assign tx_byte     = tx_sr_q[31:24];
    assign tx_valid    = (state_q == S_BUSY);
    assign rsp_waitreq = (state_q == S_BUSY);
    assign ovf         = ovf_q;

endmodule
